mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Upstream stage of the MAC chip top. Buffers host-supplied 4-bit operand pairs in a small FIFO and, once a full burst is queued, drives the MAC's `go`/`a`/`b` inputs with one pair per cycle. It then waits for the MAC's `done` and captures `sum_out` into a result register with a valid/ready handshake toward the host.

## Interface
- `DATA_W`, 4: operand width of `a` and `b`.
- `SUM_W`, 12: width of the MAC result.
- `DEPTH`, 16: FIFO entries (power of 2).
- `BURST_LEN`, 10: pairs per MAC operation (1..DEPTH).
- `TIMEOUT`, 255: watchdog limit in cycles (only with the macro).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: host operand pair valid.
- `in_ready` out 1: FIFO can accept (`!full`).
- `in_a` in DATA_W: operand a.
- `in_b` in DATA_W: operand b.
- `go` out 1: one-cycle start pulse to the MAC.
- `a` out DATA_W: operand a to the MAC.
- `b` out DATA_W: operand b to the MAC.
- `done` in 1: MAC completion pulse.
- `sum_out` in SUM_W: MAC result, sampled when `done`=1.
- `res_valid` out 1: result held.
- `res_ready` in 1: host consumes the result.
- `res_data` out SUM_W: captured result.
- `err` out 1: sticky watchdog flag (tied 0 without the macro).

## Operation
- Push: `in_valid & in_ready` writes `{in_a,in_b}`. `in_ready` = `!full`. A pop in the same cycle does not open a slot for a push into a full FIFO (no bypass).
- FSM states: IDLE, GO, STREAM, WAIT_DONE.
- IDLE -> GO when `count >= BURST_LEN` and `!res_valid`.
- GO: assert `go` and present pair 0 on `a`/`b`, then pop. Next state is STREAM, or WAIT_DONE if BURST_LEN=1.
- STREAM: present and pop one pair per cycle. The burst counter counts to BURST_LEN-1, then the FSM goes to WAIT_DONE.
- WAIT_DONE: on `done`=1, `res_data`<=`sum_out`, `res_valid`<=1, FSM -> IDLE. `done` in any other state is ignored.
- `a`/`b` = 0 outside GO/STREAM. `go`=1 only in GO.
- `res_valid` clears on `res_valid & res_ready`. A new burst cannot start until it clears, so a result is never overwritten.
- FIFO underflow cannot occur because start requires a full burst queued. Pushes continue during a burst.
- Pointers wrap modulo DEPTH. `count` has width log2(DEPTH)+1.

## Timing
- Reset values: `go`=0, `a`=`b`=0, `res_valid`=0, `res_data`=0, `err`=0, FIFO empty so `in_ready`=1, FSM=IDLE.
- `rst_n` low mid-burst aborts immediately. All queued pairs are discarded and no partial `go`/operands follow.
- The edge where `count` reaches BURST_LEN puts the FSM in GO on the next cycle.
- `go` rises in cycle T0. Pair k is on `a`/`b` in cycle T0+k. Outputs are registered.
- `done` sampled at edge E gives `res_valid`=1 in the cycle after E.
- `res_ready` with `res_valid` at edge E lets IDLE->GO happen at the earliest at edge E+1.

## Configuration
- `MAC_FEEDER_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts cycles in WAIT_DONE.
  - On reaching TIMEOUT without `done`: `err`<=1 (sticky until reset), `res_valid` stays 0, FSM -> IDLE.
- Not defined: no counter, `err` tied 0, WAIT_DONE waits indefinitely.

## Structure
- `mac_feeder_pkg`: FSM state enum (IDLE/GO/STREAM/WAIT_DONE) and default width constants `DATA_W`=4, `SUM_W`=12.
- One sub-module, `mac_feeder_fifo`: synchronous FIFO with DEPTH×(2·DATA_W) storage, push/pop, full/empty/count.
- The top level holds the FSM, burst counter, result register and optional watchdog.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles -> all outputs at reset values, `in_ready`=1.
- Burst:
  - Stimulus: push (i, (2i+1) mod 16) for i=0..9, with the model asserting `done` and `sum_out`=12'h1A5 four cycles after the last pair.
  - Required: one `go` pulse, then `a`/`b` = 0/1, 1/3, …, 9/3 on consecutive cycles, then `res_valid`=1 with `res_data`=12'h1A5.
- Backpressure:
  - Push 16 pairs with BURST_LEN=10 and `res_ready`=0 -> `in_ready`=0 after the 16th.
  - The first burst streams, then no second `go` until `res_ready`=1.
- Underfill: push 9 pairs -> `go` never asserts. The 10th push -> `go` on the next cycle.
- Reset mid-burst: drop `rst_n` on pair 4 -> `go`/`a`/`b` go to 0 at once. After release, FIFO is empty and no stale pairs appear.
- Watchdog (macro on, TIMEOUT=20): no `done` after the burst -> `err`=1 20 cycles into WAIT_DONE, `res_valid`=0, FSM back in IDLE.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
// ---------------------------------------------------------------------------
// mac_feeder_pkg
//   Shared definitions for the MAC operand feeder:
//     - feeder_state_e : feeder FSM states (IDLE, GO, STREAM, WAIT_DONE)
//     - DATA_W_DEF     : default operand width (4)
//     - SUM_W_DEF      : default MAC result width (12)
// ---------------------------------------------------------------------------
package mac_feeder_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int SUM_W_DEF  = 12;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GO        = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_e;

endpackage : mac_feeder_pkg

// File: rtl/mac_feeder_fifo.sv
// ---------------------------------------------------------------------------
// mac_feeder_fifo
//   Synchronous FIFO holding DEPTH operand pairs of 2*DATA_W bits each.
//   Ports:
//     clk_i, rst_n_i : clock, asynchronous active-low reset
//     push_i         : write wdata_i (ignored while full)
//     pop_i          : drop the head entry
//     wdata_i        : pair to write, {a,b}
//     rdata_o        : current head entry (combinational read)
//     full_o/empty_o : occupancy flags
//     count_o        : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module mac_feeder_fifo
  import mac_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [2*DATA_W-1:0]      wdata_i,
  output logic [2*DATA_W-1:0]      rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int W     = 2 * DATA_W;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a same-cycle pop never
  // frees a slot for a push into a full FIFO. A pop on an empty FIFO is
  // only honoured together with a push (the caller bypasses the data).
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & (~empty_o | push_ok_s);

  // Storage array; no reset needed because pointers guard every read.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : mac_feeder_fifo

// File: rtl/mac_operand_feeder.sv
// ---------------------------------------------------------------------------
// mac_operand_feeder
//   Buffers host operand pairs and, once BURST_LEN pairs are available,
//   streams them to the MAC (go pulse with pair 0, then one pair per cycle).
//   Waits for the MAC done pulse and holds sum_out in a result register
//   offered to the host with a valid/ready handshake.
//
//   Optional feature macro: MAC_FEEDER_TIMEOUT_EN
//     defined   : 8-bit watchdog in WAIT_DONE; after TIMEOUT cycles without
//                 done, err is set (sticky) and the FSM returns to IDLE.
//     undefined : no watchdog, err tied low, WAIT_DONE waits indefinitely.
//
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     in_valid/in_ready    : host push handshake, in_ready = !full
//     in_a, in_b           : operand pair from host
//     go, a, b             : registered drive to the MAC
//     done, sum_out        : MAC completion pulse and result
//     res_valid/res_ready  : result handshake toward the host
//     res_data             : captured result
//     err                  : sticky watchdog flag
// ---------------------------------------------------------------------------
module mac_operand_feeder
  import mac_feeder_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SUM_W     = SUM_W_DEF,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 10
`ifdef MAC_FEEDER_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              go,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic              done,
  input  logic [SUM_W-1:0]  sum_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SUM_W-1:0]  res_data,
  output logic              err
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int PAIR_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [CNT_W:0]   BURST_LEN_W = (CNT_W + 1)'(BURST_LEN);

  feeder_state_e      state_q;
  logic               go_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [CNT_W-1:0]   burst_q;
  logic               res_valid_q;
  logic [SUM_W-1:0]   res_data_q;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic [PAIR_W-1:0]  fifo_rdata_s;
  logic               push_s;
  logic               pop_s;
  logic               start_s;
  logic [CNT_W:0]     avail_s;
  logic [PAIR_W-1:0]  head_s;
  logic [DATA_W-1:0]  head_a_s;
  logic [DATA_W-1:0]  head_b_s;

  assign push_s   = in_valid & ~fifo_full_s;
  assign in_ready = ~fifo_full_s;

  // Pairs available at the coming edge, counting an accepted push. This
  // lets the burst start on the same edge that completes it, so go is seen
  // in the cycle right after the BURST_LEN-th push.
  assign avail_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, push_s};
  assign start_s = (avail_s >= BURST_LEN_W) & ~res_valid_q;

  // With an empty FIFO (only possible when BURST_LEN is 1) the first pair
  // is the one being pushed right now.
  assign head_s   = fifo_empty_s ? {in_a, in_b} : fifo_rdata_s;
  assign head_a_s = head_s[PAIR_W-1:DATA_W];
  assign head_b_s = head_s[DATA_W-1:0];

  mac_feeder_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({in_a, in_b}),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

`ifdef MAC_FEEDER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_q;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Pop decision: each pop loads the head pair into the operand registers
  // at the same edge, so burst_q counts pairs already presented.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      GO, STREAM: begin
        if (burst_q < BURST_LEN_C) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      WAIT_DONE: pop_s = 1'b0;
      default:   pop_s = 1'b0;
    endcase
  end

  // Feeder FSM with registered go/a/b, burst counter, result register and
  // optional watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      go_q        <= 1'b0;
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      burst_q     <= {CNT_W{1'b0}};
      res_valid_q <= 1'b0;
      res_data_q  <= {SUM_W{1'b0}};
`ifdef MAC_FEEDER_TIMEOUT_EN
      wd_q        <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      // Host consumption; a capture below can only happen while
      // res_valid_q is low, so the two never collide.
      if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            state_q <= GO;
            go_q    <= 1'b1;
            a_q     <= head_a_s;
            b_q     <= head_b_s;
            burst_q <= CNT_W'(1);
          end else begin
            go_q    <= 1'b0;
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
          end
        end
        GO, STREAM: begin
          go_q <= 1'b0;
          if (pop_s) begin
            state_q <= STREAM;
            a_q     <= head_a_s;
            b_q     <= head_b_s;
            burst_q <= burst_q + CNT_W'(1);
          end else begin
            state_q <= WAIT_DONE;
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
`ifdef MAC_FEEDER_TIMEOUT_EN
            wd_q    <= 8'd0;
`endif
          end
        end
        WAIT_DONE: begin
          go_q <= 1'b0;
          a_q  <= {DATA_W{1'b0}};
          b_q  <= {DATA_W{1'b0}};
          if (done) begin
            res_data_q  <= sum_out;
            res_valid_q <= 1'b1;
            state_q     <= IDLE;
`ifdef MAC_FEEDER_TIMEOUT_EN
          end else if (wd_q == TIMEOUT_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wd_q    <= wd_q + 8'd1;
          end
`else
          end else begin
            state_q <= WAIT_DONE;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          go_q    <= 1'b0;
          a_q     <= {DATA_W{1'b0}};
          b_q     <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign go        = go_q;
  assign a         = a_q;
  assign b         = b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule : mac_operand_feeder

// File: tb/tb_mac_operand_feeder.sv
module tb_mac_operand_feeder;

  localparam int BURST = 10;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        go;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        done;
  logic [11:0] sum_out;
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_data;
  logic        err;

  logic [7:0]  exp_pair_q [$];
  logic [11:0] exp_res_q  [$];
  int          tests_run;
  int          tests_failed;
  int          go_cnt;
  bit          in_burst;
  int          idx;
  bit          mac_en;
  logic [11:0] mac_sum;
  logic [7:0]  vec_b1 [10];

  mac_operand_feeder #(
    .DATA_W    (4),
    .SUM_W     (12),
    .DEPTH     (16),
    .BURST_LEN (BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .go        (go),
    .a         (a),
    .b         (b),
    .done      (done),
    .sum_out   (sum_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves at the next negedge with in_valid low.
  task automatic push_pair(input logic [7:0] pair);
    in_a     = pair[7:4];
    in_b     = pair[3:0];
    in_valid = 1'b1;
    if (in_ready) exp_pair_q.push_back(pair);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int n;
    n = 0;
    while (exp_res_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_res_q.size()), 32'd0);
  endtask

  // Monitor / scoreboard: compares every presented pair and every consumed result.
  initial begin
    in_burst = 1'b0;
    idx      = 0;
    go_cnt   = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_pair_q.delete();
        in_burst = 1'b0;
        idx      = 0;
      end else begin
        if (go) begin
          check("go_single_pulse", 32'(in_burst), 32'd0);
          go_cnt++;
          in_burst = 1'b1;
          idx      = 0;
        end
        if (in_burst) begin
          if (exp_pair_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL pair_unexpected: got %h expected none", {a, b});
          end else begin
            check("pair", 32'({a, b}), 32'(exp_pair_q.pop_front()));
          end
          idx++;
          if (idx == BURST) in_burst = 1'b0;
        end else begin
          check("ab_idle_zero", 32'({go, a, b}), 32'd0);
        end
        if (res_valid && res_ready) begin
          if (exp_res_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL res_unexpected: got %h expected none", res_data);
          end else begin
            check("res_data", 32'(res_data), 32'(exp_res_q.pop_front()));
          end
        end
      end
    end
  end

  // MAC model: done with mac_sum four cycles after the last pair (go + 13).
  initial begin
    done    = 1'b0;
    sum_out = 12'h000;
    forever begin
      @(negedge clk);
      if (rst_n && go && mac_en) begin
        repeat (13) @(negedge clk);
        done    = 1'b1;
        sum_out = mac_sum;
        @(negedge clk);
        done    = 1'b0;
        sum_out = 12'h000;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_a         = 4'h0;
    in_b         = 4'h0;
    res_ready    = 1'b0;
    mac_en       = 1'b1;
    mac_sum      = 12'h000;
    vec_b1 = '{8'h01, 8'h13, 8'h25, 8'h37, 8'h49, 8'h5B, 8'h6D, 8'h7F, 8'h81, 8'h93};

    // Reset values
    repeat (5) @(negedge clk);
    check("rst_go", 32'(go), 32'd0);
    check("rst_ab", 32'({a, b}), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Underfill, then burst 1 (result held: res_ready low)
    mac_sum = 12'h1A5;
    exp_res_q.push_back(12'h1A5);
    for (int i = 0; i < 9; i++) push_pair(vec_b1[i]);
    repeat (5) begin
      @(negedge clk);
      check("underfill_no_go", 32'(go), 32'd0);
    end
    check("underfill_go_cnt", 32'(go_cnt), 32'd0);
    push_pair(vec_b1[9]);
    check("go_after_10th", 32'(go), 32'd1);
    repeat (20) @(negedge clk);
    check("b1_res_valid", 32'(res_valid), 32'd1);
    check("b1_res_data", 32'(res_data), 32'h1A5);

    // Backpressure: fill 16 while the result is unconsumed
    for (int i = 0; i < 16; i++) begin
      check("fill_in_ready", 32'(in_ready), 32'd1);
      push_pair({4'(15 - i), 4'(i)});
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    push_pair(8'hEE);
    repeat (3) @(negedge clk);
    check("bp_go_cnt", 32'(go_cnt), 32'd1);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    mac_sum = 12'h0C3;
    exp_res_q.push_back(12'h0C3);
    res_ready = 1'b1;
    wait_res("b2_results");
    check("b2_go_cnt", 32'(go_cnt), 32'd2);

    // Burst 3 from 6 leftovers plus 4 new pairs
    mac_sum = 12'h7E2;
    exp_res_q.push_back(12'h7E2);
    for (int i = 0; i < 4; i++) push_pair({4'(i + 1), 4'(i + 1)});
    check("b3_go", 32'(go), 32'd1);
    wait_res("b3_results");
    check("b3_go_cnt", 32'(go_cnt), 32'd3);

    // Reset mid-burst on pair 4
    mac_en = 1'b0;
    for (int i = 0; i < 10; i++) push_pair({4'hC, 4'(i)});
    check("b4_go", 32'(go), 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_go_ab", 32'({go, a, b}), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_res_valid", 32'(res_valid), 32'd0);
    check("post_rst_go_ab", 32'({go, a, b}), 32'd0);
    mac_en  = 1'b1;
    mac_sum = 12'h3F0;
    exp_res_q.push_back(12'h3F0);
    for (int i = 0; i < 10; i++) push_pair({4'(i), 4'hD});
    check("b5_go", 32'(go), 32'd1);
    wait_res("b5_results");
    check("final_go_cnt", 32'(go_cnt), 32'd5);
    check("final_pairs_left", 32'(exp_pair_q.size()), 32'd0);
    check("final_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mac_operand_feeder
